// File: rtl/maroc_dc_pkg.sv
// Shared types and helpers for the MAROC pulse counter bank.
// Holds the default counter width, index-width helper and readout states.
package maroc_dc_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } rd_state_e;

    function automatic int chan_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pulse_chan_counter.sv
// One pulse channel: edge detect, counter with overflow flag.
// A frame tick restarts the count with the same-cycle increment.
module pulse_chan_counter
    import maroc_dc_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int EDGE_MODE = 1,
    parameter int SATURATE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             count_en,
    input  logic             frame_tick,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    logic pulse_d;
    logic hit;
    logic incr;

    assign hit  = (EDGE_MODE != 0) ? (pulse_in & ~pulse_d) : pulse_in;
    assign incr = count_en & hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_d <= 1'b0;
            count   <= '0;
            ovf     <= 1'b0;
        end else begin
            pulse_d <= pulse_in;
            // Increment on the tick clk belongs to the new frame
            if (frame_tick) begin
                count <= CNT_W'(incr);
                ovf   <= 1'b0;
            end else if (incr) begin
                if (&count) begin
                    count <= (SATURATE != 0) ? count : '0;
                    ovf   <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_counter_bank.sv
// Multi-channel MAROC pulse counter bank with snapshot readout.
// Frames close on frame_tick; the snapshot drains one channel per beat.
module pulse_counter_bank
    import maroc_dc_pkg::*;
#(
    parameter int N_CH      = 64,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int EDGE_MODE = 1,
    parameter int SATURATE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          pulse_in,
    input  logic                     count_en,
    input  logic                     frame_tick,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CNT_W-1:0]         m_data,
    output logic [chan_w(N_CH)-1:0]  m_chan,
    output logic                     m_ovf,
    output logic                     m_last,
    output logic                     busy,
    output logic [15:0]              overrun_cnt
);

    localparam int CH_W = chan_w(N_CH);

    logic [CNT_W-1:0] cnt  [N_CH];
    logic [CNT_W-1:0] snap [N_CH];
    logic [N_CH-1:0]  ovf;
    logic [N_CH-1:0]  snap_ovf;
    logic [CH_W-1:0]  nxt;
    rd_state_e        state;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pulse_chan_counter #(
            .CNT_W     (CNT_W),
            .EDGE_MODE (EDGE_MODE),
            .SATURATE  (SATURATE)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .pulse_in   (pulse_in[i]),
            .count_en   (count_en),
            .frame_tick (frame_tick),
            .count      (cnt[i]),
            .ovf        (ovf[i])
        );
    end

    assign nxt     = m_chan + 1'b1;
    assign busy    = (state == SEND);
    assign m_valid = (state == SEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            m_chan      <= '0;
            m_data      <= '0;
            m_ovf       <= 1'b0;
            m_last      <= 1'b0;
            overrun_cnt <= '0;
            snap_ovf    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                snap[i] <= '0;
            end
        end else begin
            if (frame_tick && state == SEND && overrun_cnt != 16'hFFFF) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    // First word bypasses the snapshot being loaded this clk
                    if (frame_tick) begin
                        snap     <= cnt;
                        snap_ovf <= ovf;
                        state    <= SEND;
                        m_chan   <= '0;
                        m_data   <= cnt[0];
                        m_ovf    <= ovf[0];
                        m_last   <= 1'b0;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (m_last) begin
                            state  <= IDLE;
                            m_chan <= '0;
                            m_last <= 1'b0;
                        end else begin
                            m_chan <= nxt;
                            m_data <= snap[nxt];
                            m_ovf  <= snap_ovf[nxt];
                            m_last <= (nxt == CH_W'(N_CH - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_counter_bank.sv
// Directed bench for pulse_counter_bank: four parameter variants
// share one stimulus stream and are checked beat by beat.
module tb_pulse_counter_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pulse_in;
    logic       count_en;
    logic       frame_tick;
    logic       m_ready;

    logic        a_valid, a_ovf, a_last, a_busy;
    logic [15:0] a_data, a_ovr;
    logic [1:0]  a_chan;
    logic        b_valid, b_ovf, b_last, b_busy;
    logic [15:0] b_data, b_ovr;
    logic [1:0]  b_chan;
    logic        s_valid, s_ovf, s_last, s_busy;
    logic [3:0]  s_data;
    logic [15:0] s_ovr;
    logic [1:0]  s_chan;
    logic        w_valid, w_ovf, w_last, w_busy;
    logic [3:0]  w_data;
    logic [15:0] w_ovr;
    logic [1:0]  w_chan;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_counter_bank #(.N_CH(4), .CNT_W(16), .EDGE_MODE(1), .SATURATE(1)) u_a (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .count_en(count_en),
        .frame_tick(frame_tick), .m_valid(a_valid), .m_ready(m_ready),
        .m_data(a_data), .m_chan(a_chan), .m_ovf(a_ovf), .m_last(a_last),
        .busy(a_busy), .overrun_cnt(a_ovr));

    pulse_counter_bank #(.N_CH(4), .CNT_W(16), .EDGE_MODE(0), .SATURATE(1)) u_b (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .count_en(count_en),
        .frame_tick(frame_tick), .m_valid(b_valid), .m_ready(m_ready),
        .m_data(b_data), .m_chan(b_chan), .m_ovf(b_ovf), .m_last(b_last),
        .busy(b_busy), .overrun_cnt(b_ovr));

    pulse_counter_bank #(.N_CH(4), .CNT_W(4), .EDGE_MODE(1), .SATURATE(1)) u_s (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .count_en(count_en),
        .frame_tick(frame_tick), .m_valid(s_valid), .m_ready(m_ready),
        .m_data(s_data), .m_chan(s_chan), .m_ovf(s_ovf), .m_last(s_last),
        .busy(s_busy), .overrun_cnt(s_ovr));

    pulse_counter_bank #(.N_CH(4), .CNT_W(4), .EDGE_MODE(1), .SATURATE(0)) u_w (
        .clk(clk), .reset(reset), .pulse_in(pulse_in), .count_en(count_en),
        .frame_tick(frame_tick), .m_valid(w_valid), .m_ready(m_ready),
        .m_data(w_data), .m_chan(w_chan), .m_ovf(w_ovf), .m_last(w_last),
        .busy(w_busy), .overrun_cnt(w_ovr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulses(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = mask;
            tick();
            pulse_in = 4'b0000;
            tick();
        end
    endtask

    task automatic close_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    // Packed expectations are {ch3, ch2, ch1, ch0}
    task automatic drain(input string tag,
                         input logic [3:0][15:0] ea,
                         input logic [3:0][15:0] eb,
                         input logic [3:0][3:0]  es,
                         input logic [3:0][3:0]  ew,
                         input logic [3:0]       oa,
                         input logic [3:0]       os,
                         input logic [3:0]       ow);
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_valid"}, a_valid, 1);
            chk({tag, "_busy"},  a_busy, 1);
            chk({tag, "_chan"},  a_chan, k);
            chk({tag, "_last"},  a_last, (k == 3));
            chk({tag, "_a"},     a_data, ea[k]);
            chk({tag, "_a_ovf"}, a_ovf, oa[k]);
            chk({tag, "_b"},     b_data, eb[k]);
            chk({tag, "_s"},     s_data, es[k]);
            chk({tag, "_s_ovf"}, s_ovf, os[k]);
            chk({tag, "_w"},     w_data, ew[k]);
            chk({tag, "_w_ovf"}, w_ovf, ow[k]);
            tick();
        end
        chk({tag, "_end_valid"}, a_valid, 0);
        chk({tag, "_end_busy"},  a_busy, 0);
    endtask

    initial begin
        logic [15:0] exp4 [4];
        int          idx;
        bit          ft_done;
        bit          acc;

        reset      = 1'b1;
        pulse_in   = 4'b0000;
        count_en   = 1'b1;
        frame_tick = 1'b0;
        m_ready    = 1'b1;
        tick();
        tick();
        chk("rst_valid", a_valid, 0);
        chk("rst_busy",  a_busy, 0);
        chk("rst_chan",  a_chan, 0);
        chk("rst_last",  a_last, 0);
        chk("rst_ovr",   a_ovr, 0);
        reset = 1'b0;

        // Frame 1: five isolated pulses on ch2
        pulses(4'b0100, 5);
        close_frame();
        drain("f1", {16'd0, 16'd5, 16'd0, 16'd0},
                    {16'd0, 16'd5, 16'd0, 16'd0},
                    {4'd0, 4'd5, 4'd0, 4'd0},
                    {4'd0, 4'd5, 4'd0, 4'd0},
                    4'b0000, 4'b0000, 4'b0000);

        // Frame 2: ch0 held 20 clk, 20 edges on ch1
        pulse_in = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        pulse_in = 4'b0000;
        tick();
        pulses(4'b0010, 20);
        close_frame();
        drain("f2", {16'd0, 16'd0, 16'd20, 16'd1},
                    {16'd0, 16'd0, 16'd20, 16'd20},
                    {4'd0, 4'd0, 4'd15, 4'd1},
                    {4'd0, 4'd0, 4'd4, 4'd1},
                    4'b0000, 4'b0010, 4'b0010);

        // Frame 3: ch2 edge lands on the tick clk
        pulses(4'b1000, 3);
        pulse_in   = 4'b0100;
        frame_tick = 1'b1;
        tick();
        pulse_in   = 4'b0000;
        frame_tick = 1'b0;
        drain("f3", {16'd3, 16'd0, 16'd0, 16'd0},
                    {16'd3, 16'd0, 16'd0, 16'd0},
                    {4'd3, 4'd0, 4'd0, 4'd0},
                    {4'd3, 4'd0, 4'd0, 4'd0},
                    4'b0000, 4'b0000, 4'b0000);

        // Frame 4: random backpressure plus a tick mid-readout
        pulses(4'b0001, 2);
        close_frame();
        exp4    = '{16'd2, 16'd0, 16'd1, 16'd0};
        idx     = 0;
        ft_done = 1'b0;
        for (int c = 0; c < 200 && idx < 4; c++) begin
            chk("rnd_valid", a_valid, 1);
            if (!a_valid) break;
            chk("rnd_chan", a_chan, idx);
            chk("rnd_data", a_data, exp4[idx]);
            m_ready    = 1'($urandom_range(0, 1));
            frame_tick = (idx == 2) && !ft_done;
            if (frame_tick) ft_done = 1'b1;
            acc = m_ready;
            tick();
            frame_tick = 1'b0;
            if (acc) idx++;
        end
        chk("rnd_done", idx, 4);
        chk("rnd_busy", a_busy, 0);
        chk("rnd_ovr",  a_ovr, 1);
        m_ready = 1'b1;

        // Reset during beat 2 aborts readout and clears live counts
        pulses(4'b0010, 3);
        close_frame();
        pulse_in = 4'b0010;
        tick();
        pulse_in = 4'b0000;
        tick();
        chk("pre_rst_chan", a_chan, 2);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", a_valid, 0);
        chk("mid_rst_busy",  a_busy, 0);
        chk("mid_rst_chan",  a_chan, 0);
        chk("mid_rst_ovr",   a_ovr, 0);
        reset = 1'b0;
        pulses(4'b1000, 2);
        close_frame();
        drain("f6", {16'd2, 16'd0, 16'd0, 16'd0},
                    {16'd2, 16'd0, 16'd0, 16'd0},
                    {4'd2, 4'd0, 4'd0, 4'd0},
                    {4'd2, 4'd0, 4'd0, 4'd0},
                    4'b0000, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
